// File: rtl/core_controller_pkg.sv
// Shared configuration for the core controller: FSM states, trap causes,
// opcode constants and the legal-opcode check used in DECODE.
package pkg_config;

    localparam int OPCODE_W            = 7;
    localparam int MEM_TIMEOUT_DEFAULT = 255;

    localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_ALU    = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_ALUI   = 7'b0010011;

    // FETCH is encoded as zero so state_o reads 0 straight out of reset.
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } ctrl_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_ILLEGAL = 2'b01,
        CAUSE_IMEM    = 2'b10,
        CAUSE_DMEM    = 2'b11
    } trap_cause_t;

    function automatic logic is_legal_opcode(input logic [OPCODE_W-1:0] op);
        logic legal;
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_ALU, OP_ALUI: legal = 1'b1;
            default:                            legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/core_controller_wait_timer.sv
// Memory wait counter: counts unacknowledged cycles and flags the cycle in
// which one more miss would reach the configured timeout.
module wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

    // Expired during the TIMEOUT-th wait cycle, so an ack in that same cycle still wins.
    assign expired = (count >= CW'(TIMEOUT - 1));

endmodule

// File: rtl/core_controller.sv
// Multi-cycle core sequencer: FETCH/DECODE/EXEC/MEM/WB with memory timeouts,
// illegal-opcode trapping and a retired-instruction counter.
module core_controller
    import pkg_config::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
    parameter int INSTRET_W   = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    output logic                 imem_req_o,
    input  logic                 imem_ack_i,
    output logic                 ir_we_o,
    input  logic [OPCODE_W-1:0]  opcode_i,
    input  logic                 reg_write_i,
    input  logic                 mem_write_i,
    input  logic                 branch_i,
    input  logic                 branch_taken_i,
    output logic                 dmem_req_o,
    output logic                 dmem_we_o,
    input  logic                 dmem_ack_i,
    output logic                 rf_we_o,
    output logic                 pc_we_o,
    output logic                 pc_src_o,
    output logic                 trap_o,
    output logic [1:0]           trap_cause_o,
    output logic [2:0]           state_o,
    output logic [INSTRET_W-1:0] instret_o
);

    ctrl_state_t          state, state_next;
    trap_cause_t          trap_cause, cause_next;
    logic [INSTRET_W-1:0] instret;
    logic                 timer_clear, timer_enable, timer_expired;

    // The timer is held clear outside FETCH/MEM, so it starts from zero on every entry.
    assign timer_clear  = !((state == FETCH) || (state == MEM));
    assign timer_enable = ((state == FETCH) && !imem_ack_i) ||
                          ((state == MEM)   && !dmem_ack_i);

    wait_timer #(
        .TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk_i),
        .rst     (rst_i),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= FETCH;
            trap_cause <= CAUSE_NONE;
            instret    <= '0;
        end else begin
            state      <= state_next;
            trap_cause <= cause_next;
            if (state == WB) begin
                instret <= instret + INSTRET_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        cause_next = trap_cause;
        case (state)
            FETCH: begin
                if (imem_ack_i) begin
                    state_next = DECODE;
                end else if (timer_expired) begin
                    state_next = TRAP;
                    cause_next = CAUSE_IMEM;
                end
            end
            DECODE: begin
                if (!is_legal_opcode(opcode_i)) begin
                    state_next = TRAP;
                    cause_next = CAUSE_ILLEGAL;
                end else begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if ((opcode_i == OP_LOAD) || (opcode_i == OP_STORE)) begin
                    state_next = MEM;
                end else begin
                    state_next = WB;
                end
            end
            MEM: begin
                if (dmem_ack_i) begin
                    state_next = WB;
                end else if (timer_expired) begin
                    state_next = TRAP;
                    cause_next = CAUSE_DMEM;
                end
            end
            WB:      state_next = FETCH;
            TRAP:    state_next = TRAP;
            default: state_next = FETCH;
        endcase
    end

    // Everything is forced low while reset is held, regardless of state.
    always_comb begin
        imem_req_o   = 1'b0;
        ir_we_o      = 1'b0;
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        rf_we_o      = 1'b0;
        pc_we_o      = 1'b0;
        pc_src_o     = 1'b0;
        trap_o       = 1'b0;
        trap_cause_o = 2'b00;
        state_o      = 3'd0;
        if (!rst_i) begin
            state_o      = state;
            trap_cause_o = trap_cause;
            case (state)
                FETCH: begin
                    imem_req_o = 1'b1;
                    ir_we_o    = imem_ack_i;
                end
                MEM: begin
                    dmem_req_o = 1'b1;
                    dmem_we_o  = mem_write_i;
                end
                WB: begin
                    rf_we_o  = reg_write_i;
                    pc_we_o  = 1'b1;
                    pc_src_o = branch_i & branch_taken_i;
                end
                TRAP:    trap_o = 1'b1;
                default: ;
            endcase
        end
    end

    assign instret_o = instret;

endmodule
